// File: rtl/sata_cmd_sequencer.sv
`default_nettype none
// sata_cmd_sequencer: splits a user (direction, LBA, count) request into sata_stack commands of at
// most MAX_SECTORS sectors. Define SATA_SEQ_RETRY_EN for one retry per chunk and a retry_stb output.
module sata_cmd_sequencer #(
    parameter int unsigned MAX_SECTORS     = 256,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned CL_RESET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_stb,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [47:0] req_lba,
    input  logic [31:0] req_count,
    output logic        busy,
    output logic        done_stb,
    output logic        error_stb,
    output logic [2:0]  error_code,
    output logic [7:0]  error_status,
    output logic [47:0] error_lba,
`ifdef SATA_SEQ_RETRY_EN
    output logic        retry_stb,
`endif
    input  logic        linkup,
    input  logic        sata_ready,
    input  logic        sata_busy,
    input  logic        d2h_reg_stb,
    input  logic [7:0]  d2h_status,
    input  logic [7:0]  d2h_error,
    output logic        write_data_stb,
    output logic        read_data_stb,
    output logic [15:0] sector_count,
    output logic [47:0] sector_address,
    output logic        command_layer_reset
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_CHECK      = 3'd4,
        S_CL_RESET   = 3'd5,
        S_FAIL       = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] remaining;
    logic [31:0] timer;
    logic [47:0] cur_lba;
    logic [7:0]  lat_status;
    logic [7:0]  lat_error;
    logic        is_write;
`ifdef SATA_SEQ_RETRY_EN
    logic        retried;
    logic        retry_pending;
`endif

    logic [15:0] chunk;
    logic [48:0] req_end;
    logic        range_err;
    logic        timed_out;
    logic        advance;
    logic [2:0]  timeout_code;

    assign chunk        = (remaining > 32'(MAX_SECTORS)) ? 16'(MAX_SECTORS) : remaining[15:0];
    assign req_end      = {1'b0, req_lba} + {17'd0, req_count};
    assign range_err    = req_end > 49'h1_0000_0000_0000;
    assign req_ready    = !rst && linkup && (state == S_IDLE);
    assign timed_out    = timer >= (TIMEOUT_CYCLES - 32'd1);
    assign timeout_code = (state == S_WAIT_DONE) ? 3'd3 : 3'd2;

    // Condition that lets each wait state move on.
    always_comb begin
        advance = 1'b0;
        case (state)
            S_ISSUE:      advance = sata_ready && !sata_busy;
            S_WAIT_START: advance = sata_busy;
            S_WAIT_DONE:  advance = !sata_busy;
            default:      advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            busy                <= 1'b0;
            done_stb            <= 1'b0;
            error_stb           <= 1'b0;
            error_code          <= 3'd0;
            error_status        <= 8'd0;
            error_lba           <= 48'd0;
            write_data_stb      <= 1'b0;
            read_data_stb       <= 1'b0;
            sector_count        <= 16'd0;
            sector_address      <= 48'd0;
            command_layer_reset <= 1'b0;
            remaining           <= 32'd0;
            timer               <= 32'd0;
            cur_lba             <= 48'd0;
            lat_status          <= 8'd0;
            lat_error           <= 8'd0;
            is_write            <= 1'b0;
`ifdef SATA_SEQ_RETRY_EN
            retry_stb           <= 1'b0;
            retried             <= 1'b0;
            retry_pending       <= 1'b0;
`endif
        end else begin
            done_stb       <= 1'b0;
            error_stb      <= 1'b0;
            write_data_stb <= 1'b0;
            read_data_stb  <= 1'b0;
`ifdef SATA_SEQ_RETRY_EN
            retry_stb      <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req_stb && linkup) begin
                        error_code   <= 3'd0;
                        error_status <= 8'd0;
                        is_write     <= req_write;
                        cur_lba      <= req_lba;
                        remaining    <= req_count;
                        timer        <= 32'd0;
`ifdef SATA_SEQ_RETRY_EN
                        retried      <= 1'b0;
`endif
                        if (req_count == 32'd0) begin
                            done_stb <= 1'b1;
                        end else if (range_err) begin
                            error_code <= 3'd5;
                            error_lba  <= req_lba;
                            error_stb  <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE, S_WAIT_START, S_WAIT_DONE: begin
                    if ((state == S_WAIT_DONE) && d2h_reg_stb) begin
                        lat_status <= d2h_status;
                        lat_error  <= d2h_error;
                    end
                    if (!linkup) begin
                        error_code          <= 3'd1;
                        command_layer_reset <= 1'b1;
                        timer               <= 32'd0;
                        state               <= S_CL_RESET;
`ifdef SATA_SEQ_RETRY_EN
                        retry_pending       <= 1'b0;
`endif
                    end else if (advance) begin
                        timer <= 32'd0;
                        case (state)
                            S_ISSUE: begin
                                sector_count   <= chunk;
                                sector_address <= cur_lba;
                                write_data_stb <= is_write;
                                read_data_stb  <= !is_write;
                                lat_status     <= 8'd0;
                                lat_error      <= 8'd0;
                                state          <= S_WAIT_START;
                            end
                            S_WAIT_START: state <= S_WAIT_DONE;
                            default:      state <= S_CHECK;
                        endcase
                    end else if (timed_out) begin
                        command_layer_reset <= 1'b1;
                        timer               <= 32'd0;
                        state               <= S_CL_RESET;
`ifdef SATA_SEQ_RETRY_EN
                        if (!retried) begin
                            retried       <= 1'b1;
                            retry_pending <= 1'b1;
                            retry_stb     <= 1'b1;
                        end else begin
                            retry_pending <= 1'b0;
                            error_code    <= timeout_code;
                        end
`else
                        error_code <= timeout_code;
`endif
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                S_CHECK: begin
                    if (!linkup) begin
                        error_code          <= 3'd1;
                        command_layer_reset <= 1'b1;
                        timer               <= 32'd0;
                        state               <= S_CL_RESET;
`ifdef SATA_SEQ_RETRY_EN
                        retry_pending       <= 1'b0;
`endif
                    end else if (lat_status[0] || (lat_error != 8'd0)) begin
`ifdef SATA_SEQ_RETRY_EN
                        if (!retried) begin
                            retried   <= 1'b1;
                            retry_stb <= 1'b1;
                            timer     <= 32'd0;
                            state     <= S_ISSUE;
                        end else begin
                            error_code   <= 3'd4;
                            error_status <= lat_status;
                            state        <= S_FAIL;
                        end
`else
                        error_code   <= 3'd4;
                        error_status <= lat_status;
                        state        <= S_FAIL;
`endif
                    end else begin
                        remaining <= remaining - 32'(chunk);
                        cur_lba   <= cur_lba + 48'(chunk);
                        timer     <= 32'd0;
`ifdef SATA_SEQ_RETRY_EN
                        retried   <= 1'b0;
`endif
                        if (remaining == 32'(chunk)) begin
                            done_stb <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end

                S_CL_RESET: begin
                    if (timer >= (CL_RESET_CYCLES - 32'd1)) begin
                        command_layer_reset <= 1'b0;
                        timer               <= 32'd0;
`ifdef SATA_SEQ_RETRY_EN
                        state               <= retry_pending ? S_ISSUE : S_FAIL;
                        retry_pending       <= 1'b0;
`else
                        state               <= S_FAIL;
`endif
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                S_FAIL: begin
                    error_stb <= 1'b1;
                    error_lba <= cur_lba;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sata_cmd_sequencer.sv
`default_nettype none
// Randomized scoreboard bench for sata_cmd_sequencer driving a faux SATA drive model.
module tb_sata_cmd_sequencer;
    localparam int MAXS = 256;
    localparam int TMO  = 100;
    localparam int CLRN = 4;

    localparam int EV_STB   = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;
    localparam int EV_RETRY = 4;
    localparam int EV_CLR   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_stb = 1'b0, req_ready, req_write = 1'b0;
    logic [47:0] req_lba = 48'd0;
    logic [31:0] req_count = 32'd0;
    logic        busy, done_stb, error_stb;
    logic [2:0]  error_code;
    logic [7:0]  error_status;
    logic [47:0] error_lba;
    logic        linkup = 1'b0, sata_ready = 1'b0, sata_busy = 1'b0, d2h_reg_stb = 1'b0;
    logic [7:0]  d2h_status = 8'd0, d2h_error = 8'd0;
    logic        write_data_stb, read_data_stb, command_layer_reset;
    logic [15:0] sector_count;
    logic [47:0] sector_address;
`ifdef SATA_SEQ_RETRY_EN
    logic        retry_stb;
`else
    logic        retry_stb = 1'b0;
`endif

    always #5 clk = ~clk;

    sata_cmd_sequencer #(
        .MAX_SECTORS(MAXS), .TIMEOUT_CYCLES(TMO), .CL_RESET_CYCLES(CLRN)
    ) dut (
        .clk(clk), .rst(rst), .req_stb(req_stb), .req_ready(req_ready), .req_write(req_write),
        .req_lba(req_lba), .req_count(req_count), .busy(busy), .done_stb(done_stb),
        .error_stb(error_stb), .error_code(error_code), .error_status(error_status),
        .error_lba(error_lba),
`ifdef SATA_SEQ_RETRY_EN
        .retry_stb(retry_stb),
`endif
        .linkup(linkup), .sata_ready(sata_ready), .sata_busy(sata_busy),
        .d2h_reg_stb(d2h_reg_stb), .d2h_status(d2h_status), .d2h_error(d2h_error),
        .write_data_stb(write_data_stb), .read_data_stb(read_data_stb),
        .sector_count(sector_count), .sector_address(sector_address),
        .command_layer_reset(command_layer_reset)
    );

    typedef struct {
        int          kind;
        logic [47:0] a;
        logic [31:0] b;
        logic [7:0]  c;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0, n_errors = 0;
    int  cyc = 0, done_cyc = -1, err_cyc = -1, acc_cyc = 0;
    bit  ignore_ev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void push(input int kind, input logic [47:0] a, input logic [31:0] b,
                                 input logic [7:0] c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endfunction

    task automatic observe(input int kind, input logic [47:0] a, input logic [31:0] b,
                           input logic [7:0] c);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%h b=%h c=%h, expected no event",
                     kind, a, b, c);
        end else begin
            e = sb.pop_front();
            chk($sformatf("event_kind%0d", e.kind), 192'({kind, a, b, c}),
                192'({e.kind, e.a, e.b, e.c}));
        end
    endtask

    // Monitor: turns DUT output activity into events and checks them against the scoreboard.
    int clr_len = 0;
    always @(negedge clk) begin
        if (rst || ignore_ev) begin
            clr_len = 0;
        end else begin
            if (command_layer_reset) clr_len++;
            else if (clr_len != 0) begin
                observe(EV_CLR, 48'd0, 32'(clr_len), 8'd0);
                clr_len = 0;
            end
            if (retry_stb) observe(EV_RETRY, 48'd0, 32'd0, 8'd0);
            if (write_data_stb || read_data_stb)
                observe(EV_STB, sector_address, {16'd0, sector_count}, {7'd0, write_data_stb});
            if (done_stb) begin
                done_cyc = cyc;
                observe(EV_DONE, 48'd0, 32'd0, 8'd0);
            end
            if (error_stb) begin
                err_cyc = cyc;
                observe(EV_ERR, error_lba, {29'd0, error_code}, error_status);
            end
            if (done_stb || error_stb)
                chk("done_error_exclusive", 192'(done_stb && error_stb), 192'd0);
        end
    end

    // Faux drive: answers each command strobe with a busy window and a D2H register FIS.
    int dr_phase = 0, dr_cnt = 0, dr_chunk = 0;
    int err_chunk = 0, hang_chunk = 0, link_chunk = 0;
    bit link_dead = 1'b0, force_down = 1'b1;
    always @(negedge clk) begin
        d2h_reg_stb = 1'b0;
        sata_ready  = ($urandom_range(0, 3) != 0);
        if (link_chunk == 0) link_dead = 1'b0;
        if (rst || command_layer_reset) begin
            dr_phase  = 0;
            sata_busy = 1'b0;
        end else begin
            case (dr_phase)
                0: if (write_data_stb || read_data_stb) begin
                    dr_chunk++;
                    dr_cnt   = int'($urandom_range(0, 2));
                    dr_phase = 1;
                end
                1: if (dr_cnt == 0) begin
                    sata_busy = 1'b1;
                    dr_cnt    = int'($urandom_range(1, 5));
                    dr_phase  = 2;
                    if (dr_chunk == link_chunk) link_dead = 1'b1;
                end else dr_cnt--;
                2: if (!(hang_chunk != 0 && dr_chunk >= hang_chunk)) begin
                    if (dr_cnt == 0) begin
                        d2h_reg_stb = 1'b1;
                        d2h_status  = (dr_chunk == err_chunk) ? 8'h51 : 8'h50;
                        d2h_error   = (dr_chunk == err_chunk) ? 8'h04 : 8'h00;
                        dr_phase    = 3;
                    end else dr_cnt--;
                end
                default: begin
                    sata_busy = 1'b0;
                    dr_phase  = 0;
                end
            endcase
        end
        linkup = !(link_dead || force_down);
    end

    // Reference model: expected event sequence for a request and fault (kind, 1-based chunk).
    // fkind: 0 healthy, 1 device error on first attempt, 2 drive hangs busy, 3 link drop.
    function automatic int model(input bit wr, input logic [47:0] lba, input logic [31:0] cnt,
                                 input int fkind, input int fk);
        longint unsigned rem, a, c;
        int k;
        rem = cnt;
        a   = lba;
        if (rem == 0) begin
            push(EV_DONE, 48'd0, 32'd0, 8'd0);
            return 0;
        end
        if (a + rem > 64'h1_0000_0000_0000) begin
            push(EV_ERR, lba, 32'd5, 8'd0);
            return 5;
        end
        k = 1;
        while (rem > 0) begin
            c = (rem > MAXS) ? longint'(MAXS) : rem;
            push(EV_STB, a[47:0], c[31:0], {7'd0, wr});
            if (k == fk) begin
                case (fkind)
                    1: begin
`ifdef SATA_SEQ_RETRY_EN
                        push(EV_RETRY, 48'd0, 32'd0, 8'd0);
                        push(EV_STB, a[47:0], c[31:0], {7'd0, wr});
`else
                        push(EV_ERR, a[47:0], 32'd4, 8'h51);
                        return 4;
`endif
                    end
                    2: begin
`ifdef SATA_SEQ_RETRY_EN
                        push(EV_RETRY, 48'd0, 32'd0, 8'd0);
                        push(EV_CLR, 48'd0, 32'(CLRN), 8'd0);
                        push(EV_STB, a[47:0], c[31:0], {7'd0, wr});
`endif
                        push(EV_CLR, 48'd0, 32'(CLRN), 8'd0);
                        push(EV_ERR, a[47:0], 32'd3, 8'd0);
                        return 3;
                    end
                    3: begin
                        push(EV_CLR, 48'd0, 32'(CLRN), 8'd0);
                        push(EV_ERR, a[47:0], 32'd1, 8'd0);
                        return 1;
                    end
                    default: ;
                endcase
            end
            rem = rem - c;
            a   = a + c;
            k++;
        end
        push(EV_DONE, 48'd0, 32'd0, 8'd0);
        return 0;
    endfunction

    task automatic run_req(input bit wr, input logic [47:0] lba, input logic [31:0] cnt,
                           input int fkind, input int fk, input string name);
        int exp_code, wait_n, base;
        base       = dr_chunk;
        exp_code   = model(wr, lba, cnt, fkind, fk);
        err_chunk  = (fkind == 1) ? base + fk : 0;
        hang_chunk = (fkind == 2) ? base + fk : 0;
        link_chunk = (fkind == 3) ? base + fk : 0;
        wait_n = 0;
        while (!req_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        chk({name, "_ready"}, 192'(req_ready), 192'd1);
        req_stb   = 1'b1;
        req_write = wr;
        req_lba   = lba;
        req_count = cnt;
        acc_cyc   = cyc;
        @(negedge clk);
        req_stb   = 1'b0;
        req_lba   = {16'd0, $urandom()};
        req_count = $urandom();
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 3000) begin
            @(negedge clk);
            wait_n++;
        end
        chk({name, "_pending_events"}, 192'(sb.size()), 192'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk({name, "_busy_after"}, 192'(busy), 192'd0);
        chk({name, "_error_code"}, 192'(error_code), 192'(exp_code));
        err_chunk  = 0;
        hang_chunk = 0;
        link_chunk = 0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [191:0] all_outs();
        logic [191:0] v;
        v = '0;
        v[129:0] = {req_ready, busy, done_stb, error_stb, error_code, error_status, error_lba,
                    write_data_stb, read_data_stb, sector_count, sector_address,
                    command_layer_reset};
        v[130] = retry_stb;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        logic [63:0] r;
        logic [47:0] lba;
        logic [31:0] cnt;
        int          nch, fk, fkind, base, wait_n;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 192'd0);
        rst = 1'b0;
        force_down = 1'b0;
        repeat (3) @(negedge clk);

        run_req(1'b1, 48'h1000, 32'd600, 0, 0, "write600");
        run_req(1'b0, 48'h2000, 32'd0, 0, 0, "read0");
        chk("read0_done_latency", 192'(done_cyc), 192'(acc_cyc + 1));
        run_req(1'b1, 48'hFFFF_FFFF_FFF0, 32'h20, 0, 0, "lba_range");
        chk("lba_range_err_latency", 192'(err_cyc), 192'(acc_cyc + 1));
        run_req(1'b1, 48'h5000, 32'd100, 2, 1, "hang");
        run_req(1'b1, 48'h1000, 32'd600, 1, 2, "deverr");
        run_req(1'b0, 48'h8000, 32'd300, 3, 1, "linkdrop");
        run_req(1'b1, 48'hFFFF_FFFF_FF00, 32'h100, 0, 0, "lba_top_exact");

        // Requests while the link is down must be ignored.
        force_down = 1'b1;
        repeat (2) @(negedge clk);
        req_stb = 1'b1; req_write = 1'b1; req_lba = 48'h40; req_count = 32'd10;
        repeat (2) @(negedge clk);
        req_stb = 1'b0;
        repeat (10) @(negedge clk);
        chk("ignored_req_busy", 192'(busy), 192'd0);
        force_down = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        base = dr_chunk;
        ignore_ev = 1'b1;
        req_stb = 1'b1; req_write = 1'b1; req_lba = 48'h3000; req_count = 32'd600;
        @(negedge clk);
        req_stb = 1'b0;
        wait_n = 0;
        while (dr_chunk < base + 2 && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        chk("rst_reached_chunk2", 192'(dr_chunk >= base + 2), 192'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_rst_outputs", all_outs(), 192'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ignore_ev = 1'b0;
        sb.delete();
        repeat (40) @(negedge clk);
        chk("after_rst_busy", 192'(busy), 192'd0);

        for (int i = 0; i < 12; i++) begin
            wr  = 1'($urandom_range(0, 1));
            r   = {$urandom(), $urandom()};
            cnt = $urandom_range(0, 700);
            if ($urandom_range(0, 3) == 0) lba = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 800));
            else lba = r[47:0] >> 4;
            nch   = (int'(cnt) + MAXS - 1) / MAXS;
            fkind = int'($urandom_range(0, 3));
            fk    = (nch > 0) ? int'($urandom_range(1, nch)) : 0;
            if (nch == 0) fkind = 0;
            run_req(wr, lba, cnt, fkind, fk, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sata_cmd_sequencer.md
Name: sata_cmd_sequencer

Overview:
- Sequences read/write transfers into sata_stack on behalf of one user requester.
- Accepts a (direction, LBA, sector count) request and splits it into stack commands of at most MAX_SECTORS sectors.
- Drives write_data_stb/read_data_stb, sector_count and sector_address for each chunk, tracks completion via sata_busy and d2h_reg_stb, and reports done or a coded error.
- Sits between user control logic and sata_stack, beside the user_din/user_dout PPFIFO paths.

Parameters:
- MAX_SECTORS, 256: sectors per stack command. Legal range 1..65535.
- TIMEOUT_CYCLES, 1000000: max clk cycles per wait state. Width 32.
- CL_RESET_CYCLES, 4: command_layer_reset pulse length in cycles. Must be at least 1.

Ports:
- clk  in  1  clock; stack clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_stb  in  1  request strobe; accepted only when req_ready=1.
- req_ready  out  1  sequencer is idle and linkup=1.
- req_write  in  1  1 = write to drive, 0 = read.
- req_lba  in  48  starting sector address.
- req_count  in  32  total sectors.
- busy  out  1  request in progress.
- done_stb  out  1  one-cycle pulse on successful completion.
- error_stb  out  1  one-cycle pulse on failure.
- error_code  out  3  0 none, 1 link lost, 2 start timeout, 3 completion timeout, 4 device error, 5 LBA range. Held until the next accept.
- error_status  out  8  captured d2h_status on device error.
- error_lba  out  48  sector_address of the failing chunk.
- linkup  in  1  from sata_stack.
- sata_ready  in  1  from sata_stack.
- sata_busy  in  1  from sata_stack.
- d2h_reg_stb  in  1  from sata_stack.
- d2h_status  in  8  from sata_stack.
- d2h_error  in  8  from sata_stack.
- write_data_stb  out  1  to sata_stack.
- read_data_stb  out  1  to sata_stack.
- sector_count  out  16  to sata_stack.
- sector_address  out  48  to sata_stack.
- command_layer_reset  out  1  to sata_stack.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal remaining count, LBA and timers 0. Reset is honoured in any state and aborts any transfer without pulses.
- IDLE:
  - req_ready = linkup.
  - On req_stb & req_ready, capture request and assert busy the next cycle.
  - req_count==0: done_stb 1 cycle after accept; no command issued.
  - req_lba+req_count > 2^48 (49-bit compare): error_code=5, error_stb 1 cycle after accept; no command issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Wait for sata_ready & ~sata_busy.
  - Then, for exactly 1 cycle, drive sector_count=min(remaining, MAX_SECTORS), sector_address=current LBA, and the selected strobe.
  - sector_count and sector_address stay stable from the strobe until the chunk completes.
  - Go to WAIT_START and clear the timer.
- WAIT_START: wait for sata_busy=1.
- WAIT_DONE:
  - Latch d2h_status and d2h_error on every d2h_reg_stb.
  - On sata_busy falling, go to CHECK.
- CHECK (1 cycle):
  - Device error if the latched status bit0 (ERR) = 1 or latched error != 0. Then error_code=4, error_status=latched status, go to FAIL.
  - Otherwise remaining -= chunk and LBA += chunk.
  - If remaining==0, pulse done_stb, clear busy, go to IDLE. Otherwise go to ISSUE.
- Timeouts: the timer counts in ISSUE, WAIT_START and WAIT_DONE, and clears on each state entry. Reaching TIMEOUT_CYCLES gives code 2 (ISSUE or WAIT_START) or code 3 (WAIT_DONE), then CL_RESET.
- Link loss: linkup=0 in any non-IDLE state gives code 1, then CL_RESET. Link loss takes priority over a timeout in the same cycle.
- CL_RESET: command_layer_reset=1 for CL_RESET_CYCLES, then FAIL.
- FAIL (1 cycle): pulse error_stb, set error_lba, clear busy, go to IDLE.
- Device errors go to FAIL directly, without a command-layer reset.
- A req_stb while req_ready=0 is ignored.
- done_stb and error_stb are never both high in the same cycle.

Optional Feature:
- Macro SATA_SEQ_RETRY_EN.
- Defined:
  - A chunk failing with code 2, 3 or 4 is retried once from ISSUE with the same sector_count and sector_address.
  - Code 2 and 3 failures pass through CL_RESET before the retry. Code 4 failures go straight to ISSUE.
  - A second failure of the same chunk reports normally.
  - Adds output retry_stb (1 bit), pulsed 1 cycle on each retry.
  - The retry flag clears when a chunk completes.
- Undefined: no retry; no retry_stb port.

Test Plan:
- Write, lba=0x1000, count=600, MAX_SECTORS=256, faux drive healthy:
  - Three write_data_stb pulses: (0x1000,256), (0x1100,256), (0x1200,88).
  - One done_stb, then busy=0.
- Read, count=0: done_stb 1 cycle after accept; read_data_stb never asserts.
- lba=0xFFFF_FFFF_FFF0, count=0x20: error_code=5, error_stb; no strobe issued.
- Drive holds sata_busy high, TIMEOUT_CYCLES=100:
  - error_code=3 and command_layer_reset high 4 cycles.
  - error_stb follows; error_lba = chunk address.
- d2h_reg_stb with d2h_status=0x51 on chunk 2 of 3: error_code=4, error_status=0x51, error_lba=0x1100, no done_stb. With SATA_SEQ_RETRY_EN and a clean retry: retry_stb once, then done_stb.
- linkup dropped in WAIT_DONE: error_code=1 after the CL_RESET pulse. Async rst asserted mid-transfer: all outputs 0 immediately; no pulses after release.
